// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC sequencing, redirect handling across memory wait
// states, a one-entry hold buffer for stalls, and the IF/ID pipeline register.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_nrst,
  input  logic        i_con_stall,
  input  logic        i_con_flush,
  input  logic [1:0]  i_con_jump,
  input  logic [31:0] i_addr_jump,
  input  logic [31:0] i_data_jr,
  input  logic        i_con_branch,
  input  logic [31:0] i_addr_branch,
  output logic [31:0] o_addr_imem,
  output logic        o_con_imemreq,
  input  logic        i_con_imemack,
  input  logic [31:0] i_data_imem,
  output logic [31:0] o_addr_pc4,
  output logic [31:0] o_data_instr,
  output logic        o_con_valid
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FETCH = 2'b01,
    ST_HOLD  = 2'b10
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        pend_valid_q, pend_valid_d;
  logic [31:0] pend_addr_q, pend_addr_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] pc4_q, pc4_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;

  logic        redir_s;
  logic [31:0] target_s;
  logic [31:0] pc_plus4_s;
  logic        deliver_s;
  logic [31:0] deliver_data_s;

  assign pc_plus4_s    = pc_q + 32'd4;
  assign o_con_imemreq = (state_q == ST_FETCH);
  assign o_addr_imem   = pc_q;
  assign o_addr_pc4    = pc4_q;
  assign o_data_instr  = instr_q;
  assign o_con_valid   = valid_q;

  // Redirect select: branch beats jump; jump code 11 is inert.
  always_comb begin
    redir_s  = 1'b0;
    target_s = 32'h0000_0000;
    if (i_con_branch) begin
      redir_s  = 1'b1;
      target_s = i_addr_branch;
    end else if (i_con_jump == 2'b01) begin
      redir_s  = 1'b1;
      target_s = i_addr_jump;
    end else if (i_con_jump == 2'b10) begin
      redir_s  = 1'b1;
      target_s = i_data_jr;
    end else begin
      redir_s  = 1'b0;
      target_s = 32'h0000_0000;
    end
  end

  // Next-state logic for the FSM, PC, pending redirect and hold buffer.
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    pend_valid_d   = pend_valid_q;
    pend_addr_d    = pend_addr_q;
    buf_d          = buf_q;
    deliver_s      = 1'b0;
    deliver_data_s = NOP_INSTR;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (i_con_imemack) begin
          if (redir_s || pend_valid_q) begin
            // Acked word belongs to the wrong path; the live redirect is newer than pending.
            pc_d         = redir_s ? target_s : pend_addr_q;
            pend_valid_d = 1'b0;
            pend_addr_d  = 32'h0000_0000;
          end else if (!i_con_stall) begin
            deliver_s      = 1'b1;
            deliver_data_s = i_data_imem;
            pc_d           = pc_plus4_s;
          end else begin
            buf_d   = i_data_imem;
            state_d = ST_HOLD;
          end
        end else if (redir_s) begin
          pend_valid_d = 1'b1;
          pend_addr_d  = target_s;
        end else begin
          pend_valid_d = pend_valid_q;
        end
      end
      ST_HOLD: begin
        if (redir_s) begin
          pc_d    = target_s;
          state_d = ST_FETCH;
        end else if (!i_con_stall) begin
          deliver_s      = 1'b1;
          deliver_data_s = buf_q;
          pc_d           = pc_plus4_s;
          state_d        = ST_FETCH;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // IF/ID register next value: flush > stall > delivery > bubble.
  always_comb begin
    pc4_d   = 32'h0000_0000;
    instr_d = NOP_INSTR;
    valid_d = 1'b0;
    if (i_con_flush) begin
      pc4_d   = 32'h0000_0000;
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (i_con_stall) begin
      pc4_d   = pc4_q;
      instr_d = instr_q;
      valid_d = valid_q;
    end else if (deliver_s) begin
      pc4_d   = pc_plus4_s;
      instr_d = deliver_data_s;
      valid_d = 1'b1;
    end else begin
      pc4_d   = 32'h0000_0000;
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q      <= ST_IDLE;
      pc_q         <= RESET_PC;
      pend_valid_q <= 1'b0;
      pend_addr_q  <= 32'h0000_0000;
      buf_q        <= 32'h0000_0000;
      pc4_q        <= 32'h0000_0000;
      instr_q      <= NOP_INSTR;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
      buf_q        <= buf_d;
      pc4_q        <= pc4_d;
      instr_q      <= instr_d;
      valid_q      <= valid_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a queue of expected IF/ID deliveries checked by
// an independent monitor, plus direct checks of request address/state and bubbles.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        i_clk = 1'b0;
  logic        i_nrst;
  logic        i_con_stall, i_con_flush, i_con_branch, i_con_imemack;
  logic [1:0]  i_con_jump;
  logic [31:0] i_addr_jump, i_data_jr, i_addr_branch, i_data_imem;
  logic [31:0] o_addr_imem, o_addr_pc4, o_data_instr;
  logic        o_con_imemreq, o_con_valid;
  logic        data_bad;
  logic        stall_prev;

  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] instr;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
    .i_clk         (i_clk),
    .i_nrst        (i_nrst),
    .i_con_stall   (i_con_stall),
    .i_con_flush   (i_con_flush),
    .i_con_jump    (i_con_jump),
    .i_addr_jump   (i_addr_jump),
    .i_data_jr     (i_data_jr),
    .i_con_branch  (i_con_branch),
    .i_addr_branch (i_addr_branch),
    .o_addr_imem   (o_addr_imem),
    .o_con_imemreq (o_con_imemreq),
    .i_con_imemack (i_con_imemack),
    .i_data_imem   (i_data_imem),
    .o_addr_pc4    (o_addr_pc4),
    .o_data_instr  (o_data_instr),
    .o_con_valid   (o_con_valid)
  );

  always #5 i_clk = ~i_clk;

  // Memory model: word at address A is 32'h1111_0000 + A, or junk when data_bad.
  always_comb i_data_imem = data_bad ? 32'hDEAD_BEEF : (32'h1111_0000 + o_addr_imem);

  // Stall seen at the last edge: a valid IF/ID after a non-stalled edge is a new delivery.
  always @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) stall_prev <= 1'b0;
    else         stall_prev <= i_con_stall;
  end

  // Monitor: pop and compare each fresh delivery.
  always @(negedge i_clk) begin
    exp_t e;
    if (i_nrst && o_con_valid && !stall_prev) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_delivery: got pc4=%h instr=%h, required no delivery", o_addr_pc4, o_data_instr);
      end else begin
        e = exp_q.pop_front();
        if (o_addr_pc4 !== e.pc4 || o_data_instr !== e.instr) begin
          miscompares++;
          $display("FAIL ifid_delivery: got pc4=%h instr=%h, required pc4=%h instr=%h",
                   o_addr_pc4, o_data_instr, e.pc4, e.instr);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic push(input logic [31:0] pc4, input logic [31:0] instr);
    exp_q.push_back({pc4, instr});
  endtask

  initial begin
    i_nrst = 1'b0; i_con_stall = 1'b0; i_con_flush = 1'b0; i_con_branch = 1'b0;
    i_con_imemack = 1'b0; i_con_jump = 2'b00; i_addr_jump = 32'h0; i_data_jr = 32'h0;
    i_addr_branch = 32'h0; data_bad = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_req",   {31'b0, o_con_imemreq}, 32'd0);
    chk("rst_addr",  o_addr_imem, 32'h0);
    chk("rst_pc4",   o_addr_pc4, 32'h0);
    chk("rst_instr", o_data_instr, NOP);
    chk("rst_valid", {31'b0, o_con_valid}, 32'd0);

    i_nrst = 1'b1;
    tick();
    chk("idle_to_fetch_req", {31'b0, o_con_imemreq}, 32'd1);
    chk("first_addr", o_addr_imem, 32'h0);
    chk("idle_bubble", {31'b0, o_con_valid}, 32'd0);

    // Zero-wait stream, then two wait cycles at pc=8.
    push(32'd4, 32'h1111_0000);
    push(32'd8, 32'h1111_0004);
    push(32'd12, 32'h1111_0008);
    i_con_imemack = 1'b1;
    tick(); tick();
    chk("addr_pc8", o_addr_imem, 32'd8);
    i_con_imemack = 1'b0;
    tick();
    chk("wait1_addr", o_addr_imem, 32'd8);
    chk("wait1_bubble", {31'b0, o_con_valid}, 32'd0);
    tick();
    chk("wait2_addr", o_addr_imem, 32'd8);
    chk("wait2_bubble", {31'b0, o_con_valid}, 32'd0);
    i_con_imemack = 1'b1;
    tick();
    push(32'd16, 32'h1111_000C);
    tick();

    // Branch during a wait at pc=16, resolved by the later ack.
    i_con_imemack = 1'b0; i_con_branch = 1'b1; i_addr_branch = 32'h100;
    tick();
    chk("branch_wait_addr_held", o_addr_imem, 32'd16);
    i_con_branch = 1'b0;
    tick();
    chk("pending_addr_held", o_addr_imem, 32'd16);
    i_con_imemack = 1'b1;
    tick();
    chk("branch_target_addr", o_addr_imem, 32'h100);
    chk("branch_word_killed", {31'b0, o_con_valid}, 32'd0);
    push(32'h104, 32'h1111_0100);
    tick();

    // Jump with ack under stall: pc redirects, IF/ID holds.
    i_con_jump = 2'b01; i_addr_jump = 32'h14; i_con_stall = 1'b1;
    tick();
    chk("jump_addr", o_addr_imem, 32'h14);
    chk("jump_stall_ifid_held", o_addr_pc4, 32'h104);
    i_con_jump = 2'b00;
    tick();
    chk("hold_req", {31'b0, o_con_imemreq}, 32'd0);
    chk("hold_pc4", o_addr_pc4, 32'h104);
    chk("hold_valid", {31'b0, o_con_valid}, 32'd1);
    data_bad = 1'b1;
    tick();
    chk("hold2_req", {31'b0, o_con_imemreq}, 32'd0);
    chk("hold2_addr", o_addr_imem, 32'h14);
    tick();
    chk("hold3_instr", o_data_instr, 32'h1111_0100);
    push(32'h18, 32'h1111_0014);
    i_con_stall = 1'b0; i_con_imemack = 1'b0; data_bad = 1'b0;
    tick();
    chk("after_hold_req", {31'b0, o_con_imemreq}, 32'd1);
    chk("after_hold_addr", o_addr_imem, 32'h18);

    // Branch and jump together with ack: branch wins.
    i_con_imemack = 1'b1; i_con_branch = 1'b1; i_addr_branch = 32'h200;
    i_con_jump = 2'b01; i_addr_jump = 32'h300;
    tick();
    chk("branch_over_jump", o_addr_imem, 32'h200);
    chk("branch_over_jump_bubble", {31'b0, o_con_valid}, 32'd0);
    // jr pending, overwritten by a later branch, jump=11 ignored at ack.
    i_con_branch = 1'b0; i_con_jump = 2'b10; i_data_jr = 32'h400; i_con_imemack = 1'b0;
    tick();
    chk("jr_wait_addr_held", o_addr_imem, 32'h200);
    i_con_jump = 2'b00; i_con_branch = 1'b1; i_addr_branch = 32'h500;
    tick();
    i_con_branch = 1'b0; i_con_jump = 2'b11; i_addr_jump = 32'h600; i_con_imemack = 1'b1;
    tick();
    chk("pending_overwrite_addr", o_addr_imem, 32'h500);
    chk("pending_word_killed", {31'b0, o_con_valid}, 32'd0);
    i_con_jump = 2'b00;
    push(32'h504, 32'h1111_0500);
    tick();

    // Flush overrides stall; FSM still captures into HOLD.
    i_con_flush = 1'b1; i_con_stall = 1'b1;
    tick();
    chk("flush_valid", {31'b0, o_con_valid}, 32'd0);
    chk("flush_instr", o_data_instr, NOP);
    chk("flush_pc4", o_addr_pc4, 32'h0);
    chk("flush_keeps_hold", {31'b0, o_con_imemreq}, 32'd0);
    i_con_flush = 1'b0; i_con_stall = 1'b0; i_con_imemack = 1'b0;
    push(32'h508, 32'h1111_0504);
    tick();
    chk("post_flush_addr", o_addr_imem, 32'h508);

    // Asynchronous reset mid-wait.
    @(negedge i_clk);
    #1;
    i_nrst = 1'b0;
    #1;
    chk("async_rst_req", {31'b0, o_con_imemreq}, 32'd0);
    chk("async_rst_addr", o_addr_imem, 32'h0);
    chk("async_rst_pc4", o_addr_pc4, 32'h0);
    chk("async_rst_instr", o_data_instr, NOP);
    chk("async_rst_valid", {31'b0, o_con_valid}, 32'd0);
    @(posedge i_clk);
    #1;
    i_nrst = 1'b1;
    tick();
    chk("rerun_addr", o_addr_imem, 32'h0);
    push(32'd4, 32'h1111_0000);
    i_con_imemack = 1'b1;
    tick();
    i_con_imemack = 1'b0;
    tick();
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 The block SHALL have parameter NOP_INSTR, default 32'h0000_0000, meaning the instruction word presented on a bubble.
REQ-003 i_clk  in  1  the single clock; all state SHALL update on its rising edge.
REQ-004 i_nrst  in  1  reset; asynchronous assertion, active-low.
REQ-005 i_con_stall  in  1  downstream hazard hold: keep IF/ID contents and do not advance the PC.
REQ-006 i_con_flush  in  1  kill the IF/ID contents: load a bubble.
REQ-007 i_con_jump  in  2  00 = none, 01 = jump to i_addr_jump, 10 = jump to i_data_jr, 11 = treated as none.
REQ-008 i_addr_jump  in  32  absolute jump target.
REQ-009 i_data_jr  in  32  register jump target.
REQ-010 i_con_branch  in  1  taken-branch redirect.
REQ-011 i_addr_branch  in  32  branch target.
REQ-012 o_addr_imem  out  32  instruction memory address.
REQ-013 o_con_imemreq  out  1  instruction memory request.
REQ-014 i_con_imemack  in  1  instruction memory acknowledge; data is valid in the same cycle.
REQ-015 i_data_imem  in  32  instruction memory read data.
REQ-016 o_addr_pc4  out  32  IF/ID register: PC+4 of the delivered instruction.
REQ-017 o_data_instr  out  32  IF/ID register: the delivered instruction.
REQ-018 o_con_valid  out  1  IF/ID register: 1 = real instruction, 0 = bubble.

Function
REQ-019 The FSM SHALL have three states:
- IDLE: reset state; no request is issued.
- FETCH: o_con_imemreq = 1 and o_addr_imem = pc.
- HOLD: an instruction has been captured while stalled; o_con_imemreq = 0.
REQ-020 IDLE SHALL go to FETCH unconditionally on the first clock edge after reset release.
REQ-021 While o_con_imemreq = 1 and i_con_imemack = 0, o_addr_imem SHALL stay constant, including when a redirect arrives.
REQ-022 Redirect priority SHALL be: i_con_branch, then i_con_jump = 01 or 10, then sequential fetch.
REQ-023 The redirect target is i_addr_branch, i_addr_jump or i_data_jr as selected by that priority.
REQ-024 A redirect that arrives in FETCH without an ack SHALL be latched into pending_valid/pending_addr.
- A later redirect arriving before the ack SHALL overwrite the pending entry.
REQ-025 On an ack in FETCH while a redirect is present in the current cycle or pending:
- the acked word SHALL be discarded;
- pc SHALL load the target, with the current-cycle redirect winning over pending;
- pending SHALL clear;
- the state SHALL stay FETCH.
REQ-026 On an ack in FETCH with no redirect and i_con_stall = 0:
- IF/ID SHALL load {pc+4, i_data_imem, valid = 1};
- pc SHALL load pc+4 (modulo 2^32).
REQ-027 On an ack in FETCH with no redirect and i_con_stall = 1:
- the word SHALL go into the hold buffer;
- pc SHALL NOT change;
- the state SHALL go to HOLD.
REQ-028 In HOLD with a redirect: the buffer SHALL be discarded, pc SHALL load the target, and the state SHALL go to FETCH.
REQ-029 In HOLD with i_con_stall = 0 and no redirect:
- IF/ID SHALL load {pc+4, buffer, 1};
- pc SHALL load pc+4;
- the state SHALL go to FETCH.
REQ-030 In any cycle where no instruction is delivered and i_con_stall = 0, IF/ID SHALL load {0, NOP_INSTR, 0}.
REQ-031 With i_con_stall = 1, IF/ID SHALL hold its value.
REQ-032 With i_con_flush = 1, IF/ID SHALL load {0, NOP_INSTR, 0}.
- Flush SHALL override stall and any delivery.
- Flush SHALL NOT affect pc, pending or the FSM state.
REQ-033 Delivery latency SHALL be one cycle: an ack at edge N is visible on the IF/ID outputs after edge N.
REQ-034 Back-to-back zero-wait acks SHALL sustain one instruction per cycle.
REQ-035 An ack or data received in IDLE or HOLD SHALL be ignored.

Reset
REQ-036 Asserting i_nrst low SHALL immediately (asynchronously) set:
- state = IDLE, pc = RESET_PC;
- pending_valid = 0, pending_addr = 0, buffer = 0;
- o_addr_pc4 = 0, o_data_instr = NOP_INSTR, o_con_valid = 0.
REQ-037 While i_nrst is low, o_con_imemreq SHALL be 0 and o_addr_imem SHALL be RESET_PC.
REQ-038 Reset asserted mid-request SHALL abandon the request; the pending redirect and the hold buffer SHALL be lost.

Verification
REQ-039 Release reset, zero-wait memory returning 32'h1111_0000+pc -> after the IDLE cycle, IF/ID sequence:
- {4, 32'h1111_0000, 1}
- {8, 32'h1111_0004, 1}
- {12, 32'h1111_0008, 1}
REQ-040 Two wait cycles on the fetch at pc=8 -> IF/ID shows two bubbles, then {12, data, 1}; o_addr_imem stays 8 throughout.
REQ-041 i_con_branch=1 with i_addr_branch=32'h100 during a wait at pc=16, then ack -> the word for 16 is never valid; the next request address is 32'h100.
REQ-042 Ack at pc=20 with i_con_stall=1 for three cycles -> state HOLD, o_con_imemreq=0, IF/ID unchanged; after stall release, IF/ID={24, word20, 1} and the next request is at 24.
REQ-043 Same cycle: i_con_branch=1 (32'h200) and i_con_jump=01 (32'h300), with an ack -> pc becomes 32'h200.
REQ-044 i_con_flush=1 together with i_con_stall=1 -> IF/ID becomes a bubble; assert i_nrst low mid-wait -> all outputs take their reset values immediately.
